sram_array_26_ctrl: RTL and testbench

- Request-side controller directly upstream of the 8192x42 single-port masked SRAM macro (array_26_ext).
- Zero-fills the array after reset, then arbitrates independent read and write valid/ready request streams onto the one RW port.
- Buffers the one-cycle-late SRAM read data into a 2-entry response queue with backpressure, so the consumer never loses data.

---
 rtl/sram_array_26_pkg.sv | 15 +
 rtl/sram_array_26_resp_fifo.sv | 58 +++++
 rtl/sram_array_26_ctrl.sv | 140 ++++++++++++++
 tb/tb_sram_array_26_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_array_26_pkg.sv
// Shared constants and FSM state encoding for the array_26 request controller.
package sram_array_26_pkg;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DEPTH  = 8192;
    localparam int unsigned DATA_W = 42;
    localparam int unsigned MASK_W = 6;
    localparam int unsigned GRAN_W = 7;

    // Controller FSM: zero-fill sweep, then normal arbitration.
    typedef logic [0:0] state_t;
    localparam state_t StInit = 1'b0;
    localparam state_t StRun  = 1'b1;

endpackage

// File: rtl/sram_array_26_resp_fifo.sv
// Two-entry response FIFO holding SRAM read data until the consumer takes it.
module sram_array_26_resp_fifo #(
    parameter int unsigned Width = 42
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [1:0]       count_o,
    output logic [Width-1:0] head_o
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    // Pointer/occupancy update; a push into a full FIFO is only honoured alongside a pop.
    always_comb begin
        do_pop   = pop_i && (count_q != 2'd0);
        do_push  = push_i && ((count_q != 2'd2) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(do_push) - 2'(do_pop);
    end

    // State registers; storage needs no reset because count gates visibility.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Head is the oldest entry; meaningless while count is zero.
    always_comb begin
        count_o = count_q;
        head_o  = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/sram_array_26_ctrl.sv
// Request-side controller for the 8192x42 masked single-port SRAM: zero-fill after reset,
// read/write arbitration onto the RW port, and a backpressured read response queue.
module sram_array_26_ctrl
    import sram_array_26_pkg::*;
#(
    parameter int unsigned ADDR_W        = sram_array_26_pkg::ADDR_W,
    parameter int unsigned DEPTH         = sram_array_26_pkg::DEPTH,
    parameter int unsigned DATA_W        = sram_array_26_pkg::DATA_W,
    parameter int unsigned MASK_W        = sram_array_26_pkg::MASK_W,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [DATA_W-1:0] rd_resp_data,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    input  logic [MASK_W-1:0] wr_req_mask,
    output logic              init_done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              p1_q, p1_d;
    logic              rd_won_last_q, rd_won_last_d;

    logic [1:0]        q_count;
    logic [DATA_W-1:0] q_head;
    logic              pop;
    logic [2:0]        rd_occ;
    logic              rd_elig;
    logic              in_run;
    logic              rd_cand, wr_cand;
    logic              gnt_rd, gnt_wr;

    // Read data arrives the cycle after issue and is captured here unconditionally;
    // the eligibility rule below guarantees there is always room for it.
    sram_array_26_resp_fifo #(
        .Width(DATA_W)
    ) u_resp_fifo (
        .clock_i    (clock),
        .reset_i    (reset),
        .push_i     (p1_q),
        .push_data_i(sram_rdata),
        .pop_i      (pop),
        .count_o    (q_count),
        .head_o     (q_head)
    );

    // Response side: visible head of the queue, suppressed while reset is held.
    always_comb begin
        rd_resp_valid = (q_count != 2'd0) && !reset;
        rd_resp_data  = q_head;
        pop           = rd_resp_valid && rd_resp_ready;
        init_done     = (state_q == StRun) && !reset;
    end

    // Arbitration: a read may issue only if queued + in-flight responses stay below two
    // after this cycle's pop; conflicts alternate, starting with the write after reset.
    always_comb begin
        rd_occ  = {1'b0, q_count} + {2'b00, p1_q} - {2'b00, pop};
        rd_elig = rd_occ < 3'd2;
        in_run  = (state_q == StRun) && !reset;
        rd_cand = in_run && rd_req_valid && rd_elig;
        wr_cand = in_run && wr_req_valid;
        gnt_rd  = rd_cand && !(wr_cand && rd_won_last_q);
        gnt_wr  = wr_cand && !(rd_cand && !rd_won_last_q);
        rd_req_ready = gnt_rd;
        wr_req_ready = gnt_wr;
    end

    // SRAM port drive: zero-fill writes during the sweep, otherwise this cycle's grant.
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_wmask = '0;
        sram_wdata = '0;
        sram_addr  = '0;
        if (!reset) begin
            if (state_q == StInit) begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_wmask = '1;
                sram_wdata = '0;
                sram_addr  = init_cnt_q;
            end else begin
                sram_en    = gnt_rd || gnt_wr;
                sram_wmode = gnt_wr;
                sram_wmask = gnt_wr ? wr_req_mask : '0;
                sram_wdata = gnt_wr ? wr_req_data : '0;
                sram_addr  = gnt_wr ? wr_req_addr : rd_req_addr;
            end
        end
    end

    // Next-state: sweep counter, FSM transition, in-flight flag and fairness bit.
    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        p1_d          = gnt_rd;
        rd_won_last_d = rd_won_last_q;
        if (state_q == StInit) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = StRun;
            end
        end
        if (rd_cand && wr_cand) begin
            rd_won_last_d = gnt_rd;
        end
    end

    // Controller state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= INIT_ON_RESET ? StInit : StRun;
            init_cnt_q    <= '0;
            p1_q          <= 1'b0;
            rd_won_last_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            p1_q          <= p1_d;
            rd_won_last_q <= rd_won_last_d;
        end
    end

endmodule

// File: tb/tb_sram_array_26_ctrl.sv
// Directed self-checking bench for sram_array_26_ctrl with a behavioural masked SRAM model.
module tb_sram_array_26_ctrl;

    localparam int AW    = 13;
    localparam int DW    = 42;
    localparam int MW    = 6;
    localparam int DEPTH = 8192;
    localparam logic [DW-1:0] JUNK = 42'h2A5_5A5A_5A5A;

    logic          clock = 1'b0;
    logic          reset;
    logic          rd_req_valid, rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic          rd_resp_valid, rd_resp_ready;
    logic [DW-1:0] rd_resp_data;
    logic          wr_req_valid, wr_req_ready;
    logic [AW-1:0] wr_req_addr;
    logic [DW-1:0] wr_req_data;
    logic [MW-1:0] wr_req_mask;
    logic          init_done;
    logic [AW-1:0] sram_addr;
    logic          sram_en, sram_wmode;
    logic [MW-1:0] sram_wmask;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    sram_array_26_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_resp_valid(rd_resp_valid),
        .rd_resp_ready(rd_resp_ready),
        .rd_resp_data (rd_resp_data),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_req_addr  (wr_req_addr),
        .wr_req_data  (wr_req_data),
        .wr_req_mask  (wr_req_mask),
        .init_done    (init_done),
        .sram_addr    (sram_addr),
        .sram_en      (sram_en),
        .sram_wmode   (sram_wmode),
        .sram_wmask   (sram_wmask),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    // SRAM macro model: never-written words read back as JUNK so the zero-fill is observable.
    logic [DW-1:0] mem [DEPTH];
    bit            written [DEPTH];
    logic [DW-1:0] cur_word;

    function automatic logic [DW-1:0] bit_mask(input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int g = 0; g < MW; g++) r[g*7 +: 7] = {7{m[g]}};
        return r;
    endfunction

    assign cur_word = written[sram_addr] ? mem[sram_addr] : JUNK;

    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                mem[sram_addr]     <= (cur_word & ~bit_mask(sram_wmask))
                                    | (sram_wdata & bit_mask(sram_wmask));
                written[sram_addr] <= 1'b1;
            end else begin
                sram_rdata <= cur_word;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Write in RUN with no competing read; entered and left at posedge+1.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [MW-1:0] m);
        wr_req_valid = 1'b1;
        wr_req_addr  = a;
        wr_req_data  = d;
        wr_req_mask  = m;
        #1;
        check("wr_ready", wr_req_ready, 1);
        check("wr_sram_wmode", sram_wmode, 1);
        check("wr_sram_wmask", sram_wmask, m);
        cyc();
        wr_req_valid = 1'b0;
    endtask

    // Single read with an always-ready consumer: response expected exactly two cycles later.
    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_req_valid = 1'b1;
        rd_req_addr  = a;
        #1;
        check({tag, "_rd_ready"}, rd_req_ready, 1);
        cyc();
        rd_req_valid = 1'b0;
        #1;
        check({tag, "_valid_t1"}, rd_resp_valid, 0);
        cyc();
        #1;
        check({tag, "_valid_t2"}, rd_resp_valid, 1);
        check({tag, "_data"}, rd_resp_data, exp);
        cyc();
    endtask

    // Zero-fill sweep starting in cycle 0 (time posedge+2 or later); ends in the first RUN cycle.
    task automatic sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            check({tag, "_en"}, sram_en, 1);
            check({tag, "_wmode"}, sram_wmode, 1);
            check({tag, "_wmask"}, sram_wmask, 6'h3F);
            check({tag, "_wdata"}, sram_wdata, 0);
            check({tag, "_addr"}, sram_addr, i);
            check({tag, "_init_done"}, init_done, 0);
            check({tag, "_rd_ready"}, rd_req_ready, 0);
            check({tag, "_wr_ready"}, wr_req_ready, 0);
            check({tag, "_resp_valid"}, rd_resp_valid, 0);
            cyc();
            #1;
        end
        check({tag, "_init_done_rise"}, init_done, 1);
        check({tag, "_no_stale"}, rd_resp_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bp_rdy [8];
        int bp_vld [11];
        logic [AW-1:0] bp_addr [8];
        logic [DW-1:0] bp_data [11];

        reset         = 1'b1;
        rd_req_valid  = 1'b1;
        rd_req_addr   = '0;
        rd_resp_ready = 1'b1;
        wr_req_valid  = 1'b1;
        wr_req_addr   = '0;
        wr_req_data   = '0;
        wr_req_mask   = '0;

        // Reset held: everything quiet even with requests offered.
        cyc();
        cyc();
        #1;
        check("rst_sram_en", sram_en, 0);
        check("rst_rd_ready", rd_req_ready, 0);
        check("rst_wr_ready", wr_req_ready, 0);
        check("rst_resp_valid", rd_resp_valid, 0);
        check("rst_init_done", init_done, 0);
        reset = 1'b0;
        #1;

        // Init sweep with requests held to confirm both readies stay low.
        sweep("init");
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
        cyc();
        do_read("rd0", 13'd0, 42'd0);
        do_read("rd8191", 13'd8191, 42'd0);

        // Masked writes on granules 0 and 5, then a mask-0 write that must change nothing.
        do_write(13'd5, {DW{1'b1}}, 6'b000001);
        do_read("mask_g0", 13'd5, 42'h7F);
        do_write(13'd5, {DW{1'b1}}, 6'b100000);
        do_read("mask_g5", 13'd5, {7'h7F, 28'h0, 7'h7F});
        do_write(13'd5, 42'd0, 6'b000000);
        do_read("mask_zero", 13'd5, {7'h7F, 28'h0, 7'h7F});

        // Conflict fairness on one address: W,R,W,R...; each read sees the prior write only.
        for (int k = 0; k < 10; k++) begin
            rd_req_valid = (k < 8);
            rd_req_addr  = 13'd200;
            wr_req_valid = (k < 8);
            wr_req_addr  = 13'd200;
            wr_req_data  = DW'(k + 1);
            wr_req_mask  = 6'h3F;
            #1;
            if (k < 8) begin
                check("fair_wr_gnt", wr_req_ready, (k % 2 == 0));
                check("fair_rd_gnt", rd_req_ready, (k % 2 == 1));
            end
            check("fair_resp_valid", rd_resp_valid, ((k % 2 == 1) && k >= 3));
            if ((k % 2 == 1) && k >= 3) check("fair_resp_data", rd_resp_data, k - 2);
            cyc();
        end

        // Backpressure: consumer stalled, four reads offered; only two fit until it drains.
        for (int i = 0; i < 4; i++) do_write(AW'(10 + i), DW'(256 + 10 + i), 6'h3F);
        bp_rdy  = '{1, 1, 0, 0, 0, 0, 1, 1};
        bp_addr = '{13'd10, 13'd11, 13'd12, 13'd12, 13'd12, 13'd12, 13'd12, 13'd13};
        bp_vld  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        bp_data = '{42'd0, 42'd0, 42'h10A, 42'h10A, 42'h10A, 42'h10A, 42'h10A, 42'h10B,
                    42'h10C, 42'h10D, 42'd0};
        for (int c = 0; c < 11; c++) begin
            rd_resp_ready = (c >= 6);
            rd_req_valid  = (c < 8);
            if (c < 8) rd_req_addr = bp_addr[c];
            #1;
            if (c < 8) check("bp_rd_ready", rd_req_ready, bp_rdy[c]);
            check("bp_resp_valid", rd_resp_valid, bp_vld[c]);
            if (bp_vld[c] != 0) check("bp_resp_data", rd_resp_data, bp_data[c]);
            cyc();
        end
        rd_req_valid = 1'b0;

        // Throughput: 100 back-to-back reads, last response 101 cycles after the first accept.
        for (int j = 0; j < 100; j++) do_write(AW'(1000 + j), DW'(4096 + j), 6'h3F);
        for (int j = 0; j < 103; j++) begin
            rd_req_valid = (j < 100);
            rd_req_addr  = AW'(1000 + j);
            #1;
            if (j < 100) check("tp_rd_ready", rd_req_ready, 1);
            check("tp_resp_valid", rd_resp_valid, (j >= 2 && j <= 101));
            if (j >= 2 && j <= 101) check("tp_resp_data", rd_resp_data, 4096 + j - 2);
            cyc();
        end
        rd_req_valid = 1'b0;

        // Mid-stream reset with one response queued and one read in flight.
        rd_resp_ready = 1'b0;
        rd_req_valid  = 1'b1;
        rd_req_addr   = 13'd1000;
        #1;
        check("mr_rd_ready0", rd_req_ready, 1);
        cyc();
        rd_req_addr = 13'd1001;
        #1;
        check("mr_rd_ready1", rd_req_ready, 1);
        cyc();
        rd_req_valid = 1'b0;
        #1;
        check("mr_pre_valid", rd_resp_valid, 1);
        reset = 1'b1;
        #1;
        check("mr_rst_resp_valid", rd_resp_valid, 0);
        check("mr_rst_sram_en", sram_en, 0);
        check("mr_rst_init_done", init_done, 0);
        cyc();
        reset         = 1'b0;
        rd_resp_ready = 1'b1;
        #1;
        sweep("reinit");
        cyc();
        do_read("mr_rd5", 13'd5, 42'd0);
        do_read("mr_rd1000", 13'd1000, 42'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
